// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//
// M-stage data-memory master for the 5-stage MIPS pipeline. It turns the
// load/store controls pipelined into M into a split-transaction SRAM-like
// request (address handshake, then data handshake). It replicates store data
// across byte lanes and extracts and extends load data. It also produces
// d_stall, which the hazard unit turns into stallM/stallE.
//
// Handshake: data_req stays high until the cycle with data_req & data_addr_ok.
// Once raised it is never withdrawn. data_data_ok arrives at least one cycle
// after the address handshake. A data_data_ok seen outside DATA is ignored.
//
// Optional feature macro: DATA_ALIGN_EXC_EN
//   Adds the adelM/adesM misalignment exception outputs and suppresses the
//   request for misaligned accesses. When the macro is undefined, misaligned
//   addresses pass through unchanged.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_read_enM          load in M
//   mem_write_enM         store in M (has priority over a load)
//   mem_sizeM             0=byte, 1=half, 2/3=word
//   mem_sign_extM         1=sign-extend load result
//   mem_addrM             effective address
//   mem_wdataM            right-aligned store data
//   flushM                M-stage instruction squashed
//   stall_ext             pipeline held by another source
//   data_req/wr/size/addr/wdata   request side of the memory port
//   data_addr_ok/data_ok/rdata    response side of the memory port
//   mem_rdataM            formatted load result
//   d_stall               M-stage access not yet complete
//   state_dbg             FSM state (0=IDLE, 1=ADDR, 2=DATA, 3=DONE)
//   adelM, adesM          load/store address error (DATA_ALIGN_EXC_EN only)

module data_mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_enM,
    input  logic              mem_write_enM,
    input  logic [1:0]        mem_sizeM,
    input  logic              mem_sign_extM,
    input  logic [ADDR_W-1:0] mem_addrM,
    input  logic [31:0]       mem_wdataM,
    input  logic              flushM,
    input  logic              stall_ext,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic [31:0]       mem_rdataM,
    output logic              d_stall,
    output logic [1:0]        state_dbg
`ifdef DATA_ALIGN_EXC_EN
    ,
    output logic              adelM,
    output logic              adesM
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    logic        flushed;     // instruction was squashed after the request went out
    logic [31:0] hold;        // last completed load result
    logic        access;
    logic        align_block;
    logic        req_new;
    logic        data_done;
    logic        discard;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    assign access = mem_read_enM | mem_write_enM;

`ifdef DATA_ALIGN_EXC_EN
    logic misalign;
    always_comb begin
        misalign = 1'b0;
        if (mem_sizeM == 2'd1)
            misalign = mem_addrM[0];
        else if (mem_sizeM[1])
            misalign = (mem_addrM[1:0] != 2'b00);
    end
    assign align_block = access & ~flushM & misalign;
    assign adelM       = align_block & ~mem_write_enM;
    assign adesM       = align_block & mem_write_enM;
`else
    assign align_block = 1'b0;
`endif

    // A new request starts only from IDLE. DONE still holds the same
    // instruction, so it must not be reissued.
    assign req_new   = (state == S_IDLE) & access & ~flushM & ~align_block;
    assign data_req  = req_new | (state == S_ADDR);
    assign data_done = (state == S_DATA) & data_data_ok;
    assign d_stall   = req_new | (state == S_ADDR) | ((state == S_DATA) & ~data_data_ok);
    assign discard   = flushed | flushM;
    assign state_dbg = state;

    assign data_wr   = mem_write_enM;
    assign data_size = (mem_sizeM == 2'd3) ? 2'd2 : mem_sizeM;
    assign data_addr = mem_addrM;

    always_comb begin
        case (mem_sizeM)
            2'd0:    data_wdata = {4{mem_wdataM[7:0]}};
            2'd1:    data_wdata = {2{mem_wdataM[15:0]}};
            default: data_wdata = mem_wdataM;
        endcase
    end

    // Little-endian lane extraction
    always_comb begin
        case (mem_addrM[1:0])
            2'd0:    byte_sel = data_rdata[7:0];
            2'd1:    byte_sel = data_rdata[15:8];
            2'd2:    byte_sel = data_rdata[23:16];
            default: byte_sel = data_rdata[31:24];
        endcase
        half_sel = mem_addrM[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (mem_sizeM)
            2'd0:    load_fmt = {{24{mem_sign_extM & byte_sel[7]}}, byte_sel};
            2'd1:    load_fmt = {{16{mem_sign_extM & half_sel[15]}}, half_sel};
            default: load_fmt = data_rdata;
        endcase
    end

    assign mem_rdataM = data_done ? load_fmt : hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            flushed <= 1'b0;
            hold    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    flushed <= 1'b0;
                    if (req_new)
                        state <= data_addr_ok ? S_DATA : S_ADDR;
                end
                S_ADDR: begin
                    if (flushM)
                        flushed <= 1'b1;
                    if (data_addr_ok)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (flushM)
                        flushed <= 1'b1;
                    if (data_data_ok) begin
                        if (!discard && !mem_write_enM)
                            hold <= load_fmt;
                        // A squashed instruction has nothing left to wait for in M.
                        state   <= (stall_ext && !discard) ? S_DONE : S_IDLE;
                        flushed <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!stall_ext)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
